// File: rtl/conv_pkg.sv
// Shared pixel/window types and default geometry for the 1-D convolver
// front end (conv_window_gen) and the convolution datapath.
package conv_pkg;

    localparam int unsigned CONV_D   = 640;
    localparam int unsigned CONV_K   = 3;
    localparam int unsigned CONV_PAD = 1;

    typedef logic signed [7:0] pixel_t;

    // Element 0 is the oldest pixel in the window.
    typedef pixel_t [CONV_K-1:0] window_t;

    typedef enum logic [1:0] {
        LEAD,
        RUN,
        TRAIL
    } state_t;

endpackage

// File: rtl/conv_win_shreg.sv
// K-entry pixel shift register: a push drops entry 0 and inserts din at K-1.
// q_push previews the contents as they will be after pushing din this cycle.
module conv_win_shreg
    import conv_pkg::*;
#(
    parameter int unsigned K = CONV_K
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           push,
    input  pixel_t         din,
    output pixel_t [K-1:0] q_push
);

    pixel_t [K-1:0] sr_q;
    pixel_t [K-1:0] sr_d;
    pixel_t [K-1:0] shifted;

    always_comb begin
        shifted = sr_q;
        for (int unsigned i = 0; i + 1 < K; i++) begin
            shifted[i] = sr_q[i + 1];
        end
        shifted[K-1] = din;

        sr_d = sr_q;
        if (clr) begin
            sr_d = '0;
        end else if (push) begin
            sr_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign q_push = shifted;

endmodule

// File: rtl/conv_window_gen.sv
// Streaming window generator: pads each D-pixel line with PAD pixels at both
// ends and emits K-wide windows. Define CONV_WIN_REPLICATE_EN for edge-replicate padding.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned D   = CONV_D,
    parameter int unsigned K   = CONV_K,
    parameter int unsigned PAD = CONV_PAD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  pixel_t         s_data,
    input  logic           s_last,
    output logic           m_valid,
    input  logic           m_ready,
    output pixel_t [K-1:0] m_window,
    output logic           m_last,
    output logic           err_len
);

    localparam int unsigned PW = $clog2(D + 1);
    localparam int unsigned FW = $clog2(K + 1);

    localparam logic [PW-1:0] D_LAST   = PW'(D - 1);
    localparam logic [FW-1:0] K_FULL   = FW'(K);
    localparam logic [FW-1:0] K_PRE    = FW'(K - 1);
    localparam logic [FW-1:0] PAD_LAST = FW'((PAD == 0) ? 0 : PAD - 1);

    state_t         state_q, state_d;
    logic [FW-1:0]  fill_q, fill_d;
    logic [PW-1:0]  pix_q, pix_d;
    logic [FW-1:0]  pad_q, pad_d;
    logic           err_q, err_d;
    logic           m_valid_q, m_valid_d;
    pixel_t [K-1:0] m_window_q, m_window_d;
    logic           m_last_q, m_last_d;
`ifdef CONV_WIN_REPLICATE_EN
    pixel_t         last_pix_q, last_pix_d;
`endif

    logic           pe;
    logic           push;
    pixel_t         push_data;
    logic           line_end;
    logic           line_clr;
    pixel_t [K-1:0] sr_push;

    conv_win_shreg #(
        .K(K)
    ) u_shreg (
        .clk    (clk),
        .clr    (rst),
        .push   (push),
        .din    (push_data),
        .q_push (sr_push)
    );

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        pix_d      = pix_q;
        pad_d      = pad_q;
        err_d      = err_q;
        m_valid_d  = m_valid_q;
        m_window_d = m_window_q;
        m_last_d   = m_last_q;
`ifdef CONV_WIN_REPLICATE_EN
        last_pix_d = last_pix_q;
`endif
        push      = 1'b0;
        push_data = '0;
        line_end  = 1'b0;
        line_clr  = 1'b0;
        s_ready   = 1'b0;
        pe        = !m_valid_q || m_ready;

        unique case (state_q)
            LEAD: begin
                if (PAD == 0) begin
                    state_d = RUN;
                end else begin
`ifdef CONV_WIN_REPLICATE_EN
                    // First pixel is only previewed here; RUN consumes it.
                    push      = pe && s_valid;
                    push_data = s_data;
`else
                    push      = pe;
`endif
                    if (push) begin
                        if (pad_q == PAD_LAST) begin
                            pad_d   = '0;
                            state_d = RUN;
                        end else begin
                            pad_d = pad_q + 1'b1;
                        end
                    end
                end
            end

            RUN: begin
                s_ready = pe;
                if (s_valid && pe) begin
                    push      = 1'b1;
                    push_data = s_data;
                    pix_d     = pix_q + 1'b1;
`ifdef CONV_WIN_REPLICATE_EN
                    last_pix_d = s_data;
`endif
                    if (s_last || (pix_q == D_LAST)) begin
                        state_d = TRAIL;
                        if (s_last != (pix_q == D_LAST)) begin
                            err_d = 1'b1;
                        end
                        if (PAD == 0) begin
                            line_end = 1'b1;
                        end
                    end
                end
            end

            TRAIL: begin
                if (PAD == 0) begin
                    state_d  = LEAD;
                    line_clr = 1'b1;
                end else begin
                    push = pe;
`ifdef CONV_WIN_REPLICATE_EN
                    push_data = last_pix_q;
`endif
                    if (push) begin
                        if (pad_q == PAD_LAST) begin
                            pad_d    = '0;
                            state_d  = LEAD;
                            line_end = 1'b1;
                            line_clr = 1'b1;
                        end else begin
                            pad_d = pad_q + 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = LEAD;
            end
        endcase

        if (push && (fill_q != K_FULL)) begin
            fill_d = fill_q + 1'b1;
        end
        // Restarting the fill count keeps old-line pixels out of the next line's windows.
        if (line_clr) begin
            fill_d = '0;
            pix_d  = '0;
        end

        if (m_ready) begin
            m_valid_d = 1'b0;
        end
        if (push && (fill_q >= K_PRE)) begin
            m_valid_d  = 1'b1;
            m_window_d = sr_push;
            m_last_d   = line_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LEAD;
            fill_q     <= '0;
            pix_q      <= '0;
            pad_q      <= '0;
            err_q      <= 1'b0;
            m_valid_q  <= 1'b0;
            m_window_q <= '0;
            m_last_q   <= 1'b0;
`ifdef CONV_WIN_REPLICATE_EN
            last_pix_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            pix_q      <= pix_d;
            pad_q      <= pad_d;
            err_q      <= err_d;
            m_valid_q  <= m_valid_d;
            m_window_q <= m_window_d;
            m_last_q   <= m_last_d;
`ifdef CONV_WIN_REPLICATE_EN
            last_pix_q <= last_pix_d;
`endif
        end
    end

    assign m_valid  = m_valid_q;
    assign m_window = m_window_q;
    assign m_last   = m_last_q;
    assign err_len  = err_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen (D=8, K=3, PAD=1): table-driven lines,
// hand-written corner sequences, and a randomized stream against a padded-line model.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int D   = 8;
    localparam int K   = 3;
    localparam int PAD = 1;
`ifdef CONV_WIN_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic    clk = 1'b0;
    logic    rst;
    logic    s_valid;
    logic    s_ready;
    pixel_t  s_data;
    logic    s_last;
    logic    m_valid;
    logic    m_ready;
    window_t m_window;
    logic    m_last;
    logic    err_len;

    always #5 clk = ~clk;

    conv_window_gen #(
        .D(D),
        .K(K),
        .PAD(PAD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_window (m_window),
        .m_last   (m_last),
        .err_len  (err_len)
    );

    typedef struct {
        window_t w;
        logic    last;
    } win_s;

    typedef struct {
        int      base;
        int      len;
        bit      with_last;
        int      nwin;
        window_t first;
        window_t lastw;
        bit      err;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   rdy_mode = 0;
    int   seq[$];
    int   line_cnt = 0;
    bit   exp_err  = 1'b0;
    win_s exp_q[$];
    win_s rx_q[$];
    vec_t vecs[7];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got event, expected none", name);
    endfunction

    function automatic window_t mkw(input int a, input int b, input int c);
        window_t w;
        w[0] = 8'(a);
        w[1] = 8'(b);
        w[2] = 8'(c);
        return w;
    endfunction

    function automatic window_t tail_window();
        window_t w;
        for (int k = 0; k < K; k++) w[k] = 8'(seq[seq.size() - K + k]);
        return w;
    endfunction

    // Each line is modelled as pads + pixels + pads; every K-slice is a window.
    function automatic void model_accept(input int d, input bit last);
        window_t tmp[$];
        bit      line_done;
        win_s    e;
        if (line_cnt == 0) begin
            for (int i = 0; i < PAD; i++) seq.push_back(REP ? d : 0);
        end
        seq.push_back(d);
        line_cnt++;
        if (seq.size() >= K) tmp.push_back(tail_window());
        line_done = last || (line_cnt == D);
        if (line_done) begin
            if (line_cnt != D || !last) exp_err = 1'b1;
            for (int i = 0; i < PAD; i++) begin
                seq.push_back(REP ? d : 0);
                if (seq.size() >= K) tmp.push_back(tail_window());
            end
            seq.delete();
            line_cnt = 0;
        end
        foreach (tmp[j]) begin
            e.w    = tmp[j];
            e.last = line_done && (j == tmp.size() - 1);
            exp_q.push_back(e);
        end
    endfunction

    bit      prev_stall = 1'b0;
    window_t prev_win;
    logic    prev_last;

    always @(negedge clk) begin
        win_s e;
        win_s r;
        if (rst) begin
            seq.delete();
            exp_q.delete();
            line_cnt   = 0;
            exp_err    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_window", m_window, prev_win);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid && !m_ready) check("no_accept_stalled", s_ready, 1'b0);
            if (s_valid && s_ready) model_accept(int'(s_data), s_last);
            if (m_valid && m_ready) begin
                r.w    = m_window;
                r.last = m_last;
                rx_q.push_back(r);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_window");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_window", m_window, e.w);
                    check("sb_last", m_last, e.last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_win   = m_window;
            prev_last  = m_last;
        end
    end

    initial begin
        int ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                default: m_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_pix(input int d, input bit last);
        int unsigned guard = 0;
        s_valid = 1'b1;
        s_data  = 8'(d);
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            guard++;
            if (guard > 200) begin
                fail_now("send_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int base, input int len, input bit with_last,
                             input bit gaps, input bit rnd);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send_pix(rnd ? int'($urandom_range(0, 255)) - 128 : base + i,
                     with_last && (i == len - 1));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 1'b0);
        check({tag, "_m_valid"}, m_valid, 1'b0);
        check({tag, "_m_window"}, m_window, '0);
        check({tag, "_m_last"}, m_last, 1'b0);
        check({tag, "_err_len"}, err_len, 1'b0);
    endtask

    initial begin
        int nlast;
        int mix;
        bit h8;
        bit h11;

        vecs[0] = '{1, 8, 1'b1, 8, REP ? mkw(1, 1, 2) : mkw(0, 1, 2), REP ? mkw(7, 8, 8) : mkw(7, 8, 0), 1'b0};
        vecs[1] = '{1, 5, 1'b1, 5, REP ? mkw(1, 1, 2) : mkw(0, 1, 2), REP ? mkw(4, 5, 5) : mkw(4, 5, 0), 1'b1};
        vecs[2] = '{1, 1, 1'b1, 1, REP ? mkw(1, 1, 1) : mkw(0, 1, 0), REP ? mkw(1, 1, 1) : mkw(0, 1, 0), 1'b1};
        vecs[3] = '{1, 2, 1'b1, 2, REP ? mkw(1, 1, 2) : mkw(0, 1, 2), REP ? mkw(1, 2, 2) : mkw(1, 2, 0), 1'b1};
        vecs[4] = '{1, 8, 1'b0, 8, REP ? mkw(1, 1, 2) : mkw(0, 1, 2), REP ? mkw(7, 8, 8) : mkw(7, 8, 0), 1'b1};
        vecs[5] = '{-4, 8, 1'b1, 8, REP ? mkw(-4, -4, -3) : mkw(0, -4, -3), REP ? mkw(2, 3, 3) : mkw(2, 3, 0), 1'b0};
        vecs[6] = '{120, 8, 1'b1, 8, REP ? mkw(120, 120, 121) : mkw(0, 120, 121), REP ? mkw(126, 127, 127) : mkw(126, 127, 0), 1'b0};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Table: one line per record, fresh reset each time, m_ready held high.
        foreach (vecs[t]) begin
            do_reset();
            rx_q.delete();
            send_line(vecs[t].base, vecs[t].len, vecs[t].with_last, 1'b0, 1'b0);
            drain();
            check("tbl_nwin", rx_q.size(), vecs[t].nwin);
            check("tbl_err", err_len, vecs[t].err);
            if (rx_q.size() > 0) begin
                nlast = 0;
                foreach (rx_q[i]) if (rx_q[i].last) nlast++;
                check("tbl_first", rx_q[0].w, vecs[t].first);
                check("tbl_lastw", rx_q[rx_q.size() - 1].w, vecs[t].lastw);
                check("tbl_last_flag", rx_q[rx_q.size() - 1].last, 1'b1);
                check("tbl_nlast", nlast, 1);
            end
        end

        // Output stalls with m_ready cycling 1,0,0,1.
        rdy_mode = 1;
        do_reset();
        rx_q.delete();
        send_line(1, 8, 1'b1, 1'b0, 1'b0);
        drain();
        check("stall_nwin", rx_q.size(), 8);
        check("stall_err", err_len, 1'b0);
        rdy_mode = 0;

        // Back-to-back lines must not share pixels.
        do_reset();
        rx_q.delete();
        send_line(1, 8, 1'b1, 1'b0, 1'b0);
        send_line(11, 8, 1'b1, 1'b0, 1'b0);
        drain();
        check("b2b_nwin", rx_q.size(), 16);
        if (rx_q.size() > 8) check("b2b_first2", rx_q[8].w, REP ? mkw(11, 11, 12) : mkw(0, 11, 12));
        mix = 0;
        foreach (rx_q[i]) begin
            h8  = 1'b0;
            h11 = 1'b0;
            for (int k = 0; k < K; k++) begin
                if (rx_q[i].w[k] == 8'sd8) h8 = 1'b1;
                if (rx_q[i].w[k] == 8'sd11) h11 = 1'b1;
            end
            if (h8 && h11) mix++;
        end
        check("b2b_no_mix", mix, 0);

        // Short line sets err_len, which survives a following good line.
        do_reset();
        send_line(1, 5, 1'b1, 1'b0, 1'b0);
        send_line(1, 8, 1'b1, 1'b0, 1'b0);
        drain();
        check("err_sticky", err_len, 1'b1);

        // Reset in the middle of a line, then a clean line.
        do_reset();
        send_line(1, 4, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst = 1'b0;
        rx_q.delete();
        send_line(1, 8, 1'b1, 1'b0, 1'b0);
        drain();
        check("midrst_nwin", rx_q.size(), 8);
        check("midrst_err", err_len, 1'b0);
        if (rx_q.size() == 8) begin
            check("midrst_first", rx_q[0].w, REP ? mkw(1, 1, 2) : mkw(0, 1, 2));
            check("midrst_lastw", rx_q[7].w, REP ? mkw(7, 8, 8) : mkw(7, 8, 0));
            check("midrst_last_flag", rx_q[7].last, 1'b1);
        end

        // Random stream: mixed line lengths, gaps, random backpressure.
        rdy_mode = 2;
        do_reset();
        for (int l = 0; l < 40; l++) begin
            int len;
            bit wl;
            len = $urandom_range(1, 10);
            wl  = (len <= D) && ($urandom_range(0, 3) != 0);
            send_line(0, len, wl, 1'b1, 1'b1);
        end
        send_line(5, 3, 1'b1, 1'b1, 1'b0);
        drain();
        check("rand_err", err_len, exp_err);
        rdy_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
